// File: rtl/traffic_pkg.sv
// Shared intersection definitions: light encoding, phase encoding, road index type.
package traffic_pkg;

  localparam logic [1:0] GREEN  = 2'b11;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] RED    = 2'b01;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  typedef logic [1:0] road_idx_t;

  function automatic logic [3:0] road_onehot(input road_idx_t r);
    return 4'b0001 << r;
  endfunction

  // Light shown by the active road in a given phase; all other roads are always RED.
  function automatic logic [1:0] light_of(input phase_e ph);
    case (ph)
      PH_GREEN:  return GREEN;
      PH_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of i_pend at i_start, i_start+1, ... (mod 4).
module rr_pick
  import traffic_pkg::*;
(
  input  logic [3:0] i_pend,
  input  road_idx_t  i_start,
  output road_idx_t  o_idx,
  output logic       o_valid
);

  road_idx_t w_cand;

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_cand = 2'(i_start + 2'(k));
      if (!o_valid && i_pend[w_cand]) begin
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/actuated_scheduler.sv
// Demand-actuated round-robin phase scheduler for a four-road intersection.
// Optional macro EMERGENCY_PREEMPT_EN adds the preempt_valid/preempt_road ports.
module actuated_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN    = 5,
  parameter int unsigned MAX_GREEN    = 10,
  parameter int unsigned YELLOW_TIME  = 2,
  parameter int unsigned ALL_RED_TIME = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       preempt_valid,
  input  logic [1:0] preempt_road,
`endif
  output logic [1:0] road1_state,
  output logic [1:0] road2_state,
  output logic [1:0] road3_state,
  output logic [1:0] road4_state,
  output logic [1:0] active_road,
  output logic [1:0] phase
);

  localparam int unsigned T_MAX = max3(MAX_GREEN, YELLOW_TIME, ALL_RED_TIME);
  localparam int unsigned TW    = (T_MAX > 16) ? $clog2(T_MAX) : 4;
  localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_M1 = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_M1  = TW'(ALL_RED_TIME - 1);

  phase_e          r_ph;
  road_idx_t       r_act;
  road_idx_t       r_nxt;
  logic [TW-1:0]   r_t;
  logic [3:0]      r_pend;
  logic [3:0][1:0] r_road;

  phase_e          w_ph_n;
  road_idx_t       w_act_n;
  road_idx_t       w_nxt_n;
  road_idx_t       w_nxt_eff;
  road_idx_t       w_pick_idx;
  logic            w_pick_valid;
  logic [TW-1:0]   w_t_n;
  logic [3:0]      w_pend_n;
  logic [3:0]      w_act_oh;
  logic [3:0][1:0] w_road_n;
  logic            w_enter_green;
  logic            w_pre_exit;
  logic            w_pre_hold;

  assign w_act_oh = road_onehot(r_act);

  // Searching from active+1 over the non-active pending bits; o_valid doubles as "other demand".
  rr_pick u_pick (
    .i_pend  (r_pend & ~w_act_oh),
    .i_start (2'(r_act + 2'd1)),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_pre_exit = 1'b0;
    w_pre_hold = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    w_pre_hold = preempt_valid && (r_ph == PH_GREEN) && (r_act == preempt_road);
    w_pre_exit = preempt_valid && !w_pre_hold;
    w_nxt_eff  = w_pre_exit ? preempt_road : r_nxt;
`else
    w_nxt_eff  = r_nxt;
`endif
  end

  always_comb begin
    w_ph_n        = r_ph;
    w_act_n       = r_act;
    w_nxt_n       = r_nxt;
    w_t_n         = r_t;
    w_enter_green = 1'b0;
    unique case (r_ph)
      PH_GREEN: begin
        if (w_pre_exit) begin
          w_ph_n = PH_YELLOW;
          w_t_n  = '0;
        end else if (tick) begin
          if (!w_pre_hold && w_pick_valid &&
              ((r_t >= MIN_M1 && !req[r_act]) || r_t == MAX_M1)) begin
            w_ph_n  = PH_YELLOW;
            w_t_n   = '0;
            w_nxt_n = w_pick_idx;
          end else if (r_t != MAX_M1) begin
            w_t_n = r_t + 1'b1;
          end
        end
      end
      PH_YELLOW: begin
        if (tick) begin
          if (r_t == YEL_M1) begin
            w_ph_n = PH_ALLRED;
            w_t_n  = '0;
          end else begin
            w_t_n = r_t + 1'b1;
          end
        end
      end
      PH_ALLRED: begin
        if (tick) begin
          if (r_t == AR_M1) begin
            w_ph_n        = PH_GREEN;
            w_t_n         = '0;
            w_act_n       = w_nxt_eff;
            w_enter_green = 1'b1;
          end else begin
            w_t_n = r_t + 1'b1;
          end
        end
      end
      default: begin
        w_ph_n = PH_GREEN;
        w_t_n  = '0;
      end
    endcase
    if (w_pre_exit) w_nxt_n = w_nxt_eff;
  end

  // Requests from the road currently green extend it rather than queueing it again.
  always_comb begin
    w_pend_n = (r_pend | (req & ~((r_ph == PH_GREEN) ? w_act_oh : 4'b0000)))
             & ~(w_enter_green ? road_onehot(w_nxt_eff) : 4'b0000);
    for (int unsigned i = 0; i < 4; i++) begin
      w_road_n[i] = (w_act_n == road_idx_t'(i)) ? light_of(w_ph_n) : RED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph   <= PH_GREEN;
      r_act  <= '0;
      r_nxt  <= '0;
      r_t    <= '0;
      r_pend <= '0;
      r_road <= {RED, RED, RED, GREEN};
    end else begin
      r_ph   <= w_ph_n;
      r_act  <= w_act_n;
      r_nxt  <= w_nxt_n;
      r_t    <= w_t_n;
      r_pend <= w_pend_n;
      r_road <= w_road_n;
    end
  end

  assign road1_state = r_road[0];
  assign road2_state = r_road[1];
  assign road3_state = r_road[2];
  assign road4_state = r_road[3];
  assign active_road = r_act;
  assign phase       = r_ph;

endmodule

// File: tb/tb_actuated_scheduler.sv
// Randomized and directed bench for actuated_scheduler against a tick-counting reference model.
module tb_actuated_scheduler;
  import traffic_pkg::*;

  localparam int MIN_G = 5;
  localparam int MAX_G = 10;
  localparam int YEL   = 2;
  localparam int AR    = 1;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] req  = '0;
  logic       pv   = 1'b0;
  logic [1:0] pr   = '0;
  logic [1:0] r1, r2, r3, r4, act, ph;

  int checks   = 0;
  int failures = 0;

  // Reference state: stage 0=green 1=yellow 2=all-red; m_e counts ticks spent in the stage.
  int       m_stage = 0;
  int       m_act   = 0;
  int       m_next  = 0;
  int       m_e     = 0;
  bit [3:0] m_pend  = '0;

  always #5 clk = ~clk;

  actuated_scheduler #(
    .MIN_GREEN   (MIN_G),
    .MAX_GREEN   (MAX_G),
    .YELLOW_TIME (YEL),
    .ALL_RED_TIME(AR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .req          (req),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt_valid(pv),
    .preempt_road (pr),
`endif
    .road1_state  (r1),
    .road2_state  (r2),
    .road3_state  (r3),
    .road4_state  (r4),
    .active_road  (act),
    .phase        (ph)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_light(input int road);
    if (road != m_act) return RED;
    if (m_stage == 0) return GREEN;
    if (m_stage == 1) return YELLOW;
    return RED;
  endfunction

  task automatic model_step();
    bit       other, hold, pre, enter;
    int       tgt, pick, old_stage, old_act;
    bit [3:0] old_pend, setm;
    if (rst) begin
      m_stage = 0; m_act = 0; m_next = 0; m_e = 0; m_pend = '0;
      return;
    end
    old_pend  = m_pend;
    old_stage = m_stage;
    old_act   = m_act;
    pick = -1;
    for (int k = 1; k < 4; k++)
      if (pick < 0 && old_pend[(old_act + k) % 4]) pick = (old_act + k) % 4;
    other = (pick >= 0);
    hold  = pv && old_stage == 0 && old_act == int'(pr);
    pre   = pv && !hold;
    tgt   = pre ? int'(pr) : m_next;
    enter = 0;
    if (old_stage == 0) begin
      if (pre) begin
        m_stage = 1; m_e = 0;
      end else if (tick) begin
        if (!hold && other && ((m_e >= MIN_G - 1 && !req[old_act]) || m_e >= MAX_G - 1)) begin
          m_stage = 1; m_e = 0; m_next = pick;
        end else m_e++;
      end
    end else if (old_stage == 1) begin
      if (tick) begin
        if (m_e == YEL - 1) begin m_stage = 2; m_e = 0; end
        else m_e++;
      end
    end else if (tick) begin
      if (m_e == AR - 1) begin
        m_stage = 0; m_e = 0; m_act = tgt; enter = 1;
      end else m_e++;
    end
    if (pre) m_next = int'(pr);
    for (int i = 0; i < 4; i++) setm[i] = req[i] && !(old_stage == 0 && i == old_act);
    m_pend = old_pend | setm;
    if (enter) m_pend[tgt] = 1'b0;
  endtask

  // Inputs are held stable across the edge; outputs are checked 1 time unit after it.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("phase",  32'(ph),  32'(m_stage));
    chk("active", 32'(act), 32'(m_act));
    chk("roads",  32'({r4, r3, r2, r1}),
        32'({exp_light(3), exp_light(2), exp_light(1), exp_light(0)}));
  endtask

  task automatic do_tick(input int idle);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (idle) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; req = '0; pv = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Idle: no demand, road1 holds green indefinitely.
    do_reset();
    chk("rst_roads", 32'({r4, r3, r2, r1}), 32'({RED, RED, RED, GREEN}));
    chk("rst_phase", 32'(ph), 32'(PH_GREEN));
    for (int n = 0; n < 30; n++) begin
      do_tick(2);
      chk("idle_r1", 32'(r1), 32'(GREEN));
    end

    // Single pulsed request for road3: minimum-green handover.
    do_reset();
    req = 4'b0100; step(); req = '0;
    for (int n = 1; n <= 8; n++) begin
      do_tick(1);
      if (n == 5) chk("s2_yel", 32'(r1), 32'(YELLOW));
      if (n == 7) chk("s2_allred", 32'({r4, r3, r2, r1}), 32'({RED, RED, RED, RED}));
    end
    chk("s2_r3", 32'(r3), 32'(GREEN));
    chk("s2_act", 32'(act), 32'd2);

    // Held road1 request extends green to MAX_GREEN.
    do_reset();
    req = 4'b0011; step(); req = 4'b0001;
    for (int n = 1; n <= 13; n++) begin
      do_tick(1);
      if (n == 9)  chk("s3_hold", 32'(r1), 32'(GREEN));
      if (n == 10) chk("s3_yel", 32'(r1), 32'(YELLOW));
    end
    chk("s3_r2", 32'(r2), 32'(GREEN));
    req = '0;

    // Road2 green with road1 and road4 pending: road4 is served first.
    do_reset();
    req = 4'b0010; step(); req = '0;
    repeat (8) do_tick(1);
    chk("s4_road2", 32'(act), 32'd1);
    req = 4'b1001; step(); req = '0;
    repeat (8) do_tick(1);
    chk("s4_road4", 32'(act), 32'd3);
    chk("s4_r4", 32'(r4), 32'(GREEN));
    repeat (8) do_tick(1);
    chk("s4_road1", 32'(act), 32'd0);

    // Reset during yellow clears state and pending demand.
    do_reset();
    req = 4'b0010; step(); req = '0;
    repeat (5) do_tick(0);
    step();
    chk("s5_inyel", 32'(ph), 32'(PH_YELLOW));
    rst = 1'b1; step(); rst = 1'b0;
    chk("s5_roads", 32'({r4, r3, r2, r1}), 32'({RED, RED, RED, GREEN}));
    repeat (12) do_tick(1);
    chk("s5_nopend", 32'(act), 32'd0);

`ifdef EMERGENCY_PREEMPT_EN
    do_reset();
    do_tick(1);
    pv = 1'b1; pr = 2'd2;
    step();
    chk("s6_yel", 32'(r1), 32'(YELLOW));
    repeat (3) do_tick(1);
    chk("s6_r3", 32'(r3), 32'(GREEN));
    req = 4'b1011;
    for (int n = 0; n < 20; n++) begin
      do_tick(1);
      chk("s6_hold", 32'(r3), 32'(GREEN));
    end
    pv = 1'b0; req = '0;
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      rst = ($urandom_range(0, 599) == 0);
`ifdef EMERGENCY_PREEMPT_EN
      if ($urandom_range(0, 149) == 0) pv = ~pv;
      if ($urandom_range(0, 39) == 0) pr = 2'($urandom);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
